sdram_port_arbiter: RTL

//  Sole owner of the SDRAM controller request port. Merges three request sources into one

---
 rtl/sdram_port_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - merges kvaz, floppy and refresh requests onto one SDRAM controller port
module sdram_port_arbiter #(
    parameter logic [5:0] VU_BASE        = 6'h3F,
    parameter int         REFRESH_PERIOD = 360
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        access_slot,
    input  logic [17:0] vu_adrs,
    input  logic [7:0]  vu_data_i,
    input  logic        vu_write,
    input  logic        vu_read,
    output logic [7:0]  vu_data_o,
    output logic        vu_done,
    output logic        vu_overrun,
    input  logic [22:0] disk_adrs,
    input  logic [7:0]  disk_data_i,
    output logic [7:0]  disk_data_o,
    input  logic        disk_write,
    input  logic        disk_read,
    output logic        disk_ram_busy,
    output logic [22:0] sdram_addr,
    input  logic [15:0] sdram_di,
    output logic [15:0] sdram_do,
    output logic        sdram_read,
    output logic        sdram_write,
    output logic        sdram_lb,
    output logic        sdram_ub,
    output logic        sdram_refresh,
    input  logic        sdram_busy
);
    localparam int               CNT_W      = $clog2(REFRESH_PERIOD);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_PERIOD - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
    typedef enum logic [1:0] {SRC_VU, SRC_DISK, SRC_REFRESH} src_t;

    state_t            state;
    src_t              src;
    logic              op_read;
    logic              op_hi;

    logic              vu_pend;
    logic              vu_pend_wr;
    logic [17:0]       vu_pend_adrs;
    logic [7:0]        vu_pend_data;

    logic              disk_pend_wr;
    logic [22:0]       disk_pend_adrs;
    logic [7:0]        disk_pend_data;

    logic              refresh_due;
    logic [CNT_W-1:0]  refresh_cnt;

    logic              vu_req;
    logic              disk_req;
    logic              vu_take;
    logic              op_done;
    logic [7:0]        rd_byte;

    assign vu_req   = vu_write | vu_read;
    assign disk_req = disk_write | disk_read;
    // The kvaz slot is handed to the controller on the edge that leaves IDLE.
    assign vu_take  = (state == ST_IDLE) && vu_pend;
    assign op_done  = (state == ST_WAIT) && !sdram_busy;
    assign rd_byte  = op_hi ? sdram_di[15:8] : sdram_di[7:0];

    // Kvaz request capture; a newer request overwrites one still waiting for issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            vu_pend      <= 1'b0;
            vu_pend_wr   <= 1'b0;
            vu_pend_adrs <= '0;
            vu_pend_data <= '0;
            vu_overrun   <= 1'b0;
        end else if (vu_req) begin
            vu_pend      <= 1'b1;
            vu_pend_wr   <= vu_write;
            vu_pend_adrs <= vu_adrs;
            vu_pend_data <= vu_data_i;
            vu_overrun   <= vu_pend && !vu_take;
        end else begin
            if (vu_take)
                vu_pend <= 1'b0;
            vu_overrun <= 1'b0;
        end
    end

    // Floppy request capture; held (and busy shown) until the access completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            disk_ram_busy  <= 1'b0;
            disk_pend_wr   <= 1'b0;
            disk_pend_adrs <= '0;
            disk_pend_data <= '0;
        end else if (!disk_ram_busy && disk_req) begin
            disk_ram_busy  <= 1'b1;
            disk_pend_wr   <= disk_write;
            disk_pend_adrs <= disk_adrs;
            disk_pend_data <= disk_data_i;
        end else if (op_done && src == SRC_DISK) begin
            disk_ram_busy  <= 1'b0;
        end
    end

    // Refresh interval timer; a new period wins over a same-edge refresh completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= CNT_RELOAD;
            refresh_due <= 1'b0;
        end else if (refresh_cnt == '0) begin
            refresh_cnt <= CNT_RELOAD;
            refresh_due <= 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt - 1'b1;
            if (op_done && src == SRC_REFRESH)
                refresh_due <= 1'b0;
        end
    end

    // Arbitration and controller handshake with registered command outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            src           <= SRC_VU;
            op_read       <= 1'b0;
            op_hi         <= 1'b0;
            sdram_addr    <= '0;
            sdram_do      <= '0;
            sdram_lb      <= 1'b0;
            sdram_ub      <= 1'b0;
            sdram_read    <= 1'b0;
            sdram_write   <= 1'b0;
            sdram_refresh <= 1'b0;
            vu_data_o     <= '0;
            disk_data_o   <= '0;
            vu_done       <= 1'b0;
        end else begin
            vu_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (vu_pend) begin
                        src         <= SRC_VU;
                        op_read     <= !vu_pend_wr;
                        op_hi       <= vu_pend_adrs[0];
                        sdram_addr  <= {VU_BASE, vu_pend_adrs[17:1]};
                        sdram_lb    <= !vu_pend_adrs[0];
                        sdram_ub    <= vu_pend_adrs[0];
                        sdram_do    <= {vu_pend_data, vu_pend_data};
                        sdram_read  <= !vu_pend_wr;
                        sdram_write <= vu_pend_wr;
                        state       <= ST_ISSUE;
                    end else if (access_slot && refresh_due) begin
                        src           <= SRC_REFRESH;
                        op_read       <= 1'b0;
                        sdram_refresh <= 1'b1;
                        state         <= ST_ISSUE;
                    end else if (access_slot && disk_ram_busy) begin
                        src         <= SRC_DISK;
                        op_read     <= !disk_pend_wr;
                        op_hi       <= disk_pend_adrs[0];
                        sdram_addr  <= {1'b0, disk_pend_adrs[22:1]};
                        sdram_lb    <= !disk_pend_adrs[0];
                        sdram_ub    <= disk_pend_adrs[0];
                        sdram_do    <= {disk_pend_data, disk_pend_data};
                        sdram_read  <= !disk_pend_wr;
                        sdram_write <= disk_pend_wr;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (sdram_busy) begin
                        sdram_read    <= 1'b0;
                        sdram_write   <= 1'b0;
                        sdram_refresh <= 1'b0;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!sdram_busy) begin
                        state <= ST_IDLE;
                        if (src == SRC_VU) begin
                            vu_done <= 1'b1;
                            if (op_read)
                                vu_data_o <= rd_byte;
                        end
                        if (src == SRC_DISK && op_read)
                            disk_data_o <= rd_byte;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
